// File: rtl/data_memory_pkg.sv
// Load/store control encodings shared by the data memory and its load aligner.
package data_memory_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } ls_type_t;

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load lane select with sign/zero extension for byte, halfword and word loads.
module dmem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  ls_type_t    load_store_type,
  input  logic        load_unsigned,
  output logic [31:0] read_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{offset, 3'b000} +: 8];
  // Halfword lane comes from address[1] only; address[0] is ignored.
  assign lane_h = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    read_data = '0;
    case (load_store_type)
      LS_BYTE: read_data = load_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      LS_HALF: read_data = load_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      LS_WORD: read_data = word;
      default: read_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised byte-addressable data memory: synchronous byte/half/word stores, combinational loads.
// Optional macro DMEM_READ_GATE_EN forces read_data to 0 while mem_read is low.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LOCS   = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            load_store_type,
  input  logic                  load_unsigned,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int IDX_W  = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] mem [NUM_LOCS];
  logic [WIDX_W-1:0]     word_idx;
  logic [1:0]            offset;
  logic                  in_range;
  logic [IDX_W-1:0]      word_sel;
  ls_type_t              ls;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] aligned;

  assign ls       = ls_type_t'(load_store_type);
  assign word_idx = address[ADDR_WIDTH-1:2];
  assign offset   = address[1:0];
  assign in_range = word_idx < WIDX_W'(NUM_LOCS);
  assign word_sel = in_range ? word_idx[IDX_W-1:0] : '0;

  // Store data is replicated into every lane; the byte-enable mask picks the lanes written.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = write_data;
    case (ls)
      LS_BYTE: begin
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{write_data[7:0]}};
      end
      LS_HALF: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{write_data[15:0]}};
      end
      LS_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_LOCS; i++) mem[i] <= '0;
    end else if (mem_write && in_range) begin
      for (int unsigned b = 0; b < 4; b++)
        if (byte_en[b]) mem[word_sel][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  assign rd_word = in_range ? mem[word_sel] : '0;

  dmem_load_align u_align (
    .word            (rd_word),
    .offset          (offset),
    .load_store_type (ls),
    .load_unsigned   (load_unsigned),
    .read_data       (aligned)
  );

`ifdef DMEM_READ_GATE_EN
  assign read_data = (rstn && mem_read) ? aligned : '0;
`else
  logic unused_mem_read;
  assign unused_mem_read = mem_read;
  assign read_data = rstn ? aligned : '0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: byte-array reference model, directed cases plus random traffic.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int NUM_LOCS = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  load_store_type;
  logic        load_unsigned;
  logic [31:0] read_data;

  data_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LOCS(NUM_LOCS)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .address         (address),
    .write_data      (write_data),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .load_store_type (load_store_type),
    .load_unsigned   (load_unsigned),
    .read_data       (read_data)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic        chk_req  = 1'b0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  logic [7:0] ref_mem [NUM_LOCS*4];

  function automatic void model_clear();
    for (int i = 0; i < NUM_LOCS*4; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic void model_store(logic [31:0] a, logic [31:0] wd, logic [1:0] t);
    int unsigned base;
    if ((a >> 2) >= NUM_LOCS || t == 2'b11) return;
    case (t)
      2'b00: ref_mem[a] = wd[7:0];
      2'b01: begin
        base = a & ~32'd1;
        ref_mem[base] = wd[7:0];
        ref_mem[base+1] = wd[15:8];
      end
      default: begin
        base = a & ~32'd3;
        for (int k = 0; k < 4; k++) ref_mem[base+k] = wd[8*k +: 8];
      end
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] t, logic u);
    int unsigned base;
    logic [7:0]  b;
    logic [15:0] h;
    if ((a >> 2) >= NUM_LOCS || t == 2'b11) return 32'h0;
    case (t)
      2'b00: begin
        b = ref_mem[a];
        return u ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        base = a & ~32'd1;
        h = {ref_mem[base+1], ref_mem[base]};
        return u ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        base = a & ~32'd3;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      end
    endcase
  endfunction

  // Monitor: read_data is combinational, so it is sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL scoreboard_empty actual=%08h required=<entry>", read_data);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (read_data !== e) begin
          failures++;
          $display("FAIL %s actual=%08h required=%08h", n, read_data, e);
        end
      end
    end
  end

  // One cycle starting just after a rising edge; the model commits a store at the next edge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] t, input logic u,
                       input logic chk, input logic [31:0] e, input string n);
    address = a; write_data = wd; mem_read = rd; mem_write = wr;
    load_store_type = t; load_unsigned = u;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(n);
      chk_req = 1'b1;
    end
    @(negedge clk);
    @(posedge clk);
    if (wr && rstn) model_store(a, wd, t);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] t);
    cycle(a, wd, 1'b0, 1'b1, t, 1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] t, input logic u,
                      input logic [31:0] e, input string n);
    cycle(a, 32'h0, 1'b1, 1'b0, t, u, 1'b1, e, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rwd, e;
    logic [1:0]  rt;
    logic        ru, rrd, rwr;

    rstn = 1'b0; address = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    load_store_type = LS_WORD; load_unsigned = 1'b0;
    model_clear();
    #1;
    load(32'h14, LS_WORD, 1'b0, 32'h0, "reset_load");
    rstn = 1'b1;
    load(32'h14, LS_WORD, 1'b0, 32'h0, "post_reset_load");

    store(32'h16, 32'hF0F0_F0F0, LS_BYTE);
    load(32'h16, LS_BYTE, 1'b0, 32'hFFFF_FFF0, "lb_signed");
    load(32'h16, LS_BYTE, 1'b1, 32'h0000_00F0, "lb_unsigned");
    load(32'h14, LS_WORD, 1'b0, 32'h00F0_0000, "lw_after_sb");

    store(32'h0A, 32'hF0F0_F0F0, LS_HALF);
    load(32'h0A, LS_HALF, 1'b0, 32'hFFFF_F0F0, "lh_signed");
    load(32'h0A, LS_HALF, 1'b1, 32'h0000_F0F0, "lh_unsigned");
    load(32'h0B, LS_HALF, 1'b0, 32'hFFFF_F0F0, "lh_odd_addr");
    load(32'h08, LS_WORD, 1'b0, 32'hF0F0_0000, "lw_after_sh");

    store(32'h1D, 32'hF0F0_F0F0, LS_WORD);
    load(32'h1C, LS_WORD, 1'b0, 32'hF0F0_F0F0, "lw_aligned");
    load(32'h1D, LS_WORD, 1'b1, 32'hF0F0_F0F0, "lw_misaligned");

    store(32'h00, 32'h1234_5678, LS_WORD);
    store(32'h01, 32'h0000_00AB, LS_BYTE);
    load(32'h00, LS_WORD, 1'b0, 32'h1234_AB78, "byte_merge");
    store(32'h28, 32'hDEAD_BEEF, LS_WORD);
    load(32'h28, LS_WORD, 1'b0, 32'h0, "oob_load");
    load(32'h00, LS_WORD, 1'b0, 32'h1234_AB78, "oob_no_alias");
    store(32'h00, 32'hFFFF_FFFF, LS_RSVD);
    load(32'h00, LS_WORD, 1'b0, 32'h1234_AB78, "rsvd_store_dropped");
    load(32'h00, LS_RSVD, 1'b0, 32'h0, "rsvd_load");

    store(32'h27, 32'h0000_0080, LS_BYTE);
    load(32'h27, LS_BYTE, 1'b0, 32'hFFFF_FF80, "last_byte_signed");
    load(32'h26, LS_HALF, 1'b1, 32'h0000_8000, "last_half_unsigned");

    cycle(32'h0C, 32'h1111_1111, 1'b1, 1'b1, LS_WORD, 1'b0, 1'b1, 32'h0, "rw_old_data");
    load(32'h0C, LS_WORD, 1'b0, 32'h1111_1111, "rw_new_data");

`ifdef DMEM_READ_GATE_EN
    cycle(32'h0C, 32'h0, 1'b0, 1'b0, LS_WORD, 1'b0, 1'b1, 32'h0, "read_gated");
`else
    cycle(32'h0C, 32'h0, 1'b0, 1'b0, LS_WORD, 1'b0, 1'b1, 32'h1111_1111, "read_ungated");
`endif

    for (int i = 0; i < 300; i++) begin
      ra  = 32'($urandom_range(0, 47));
      rwd = $urandom;
      rt  = 2'($urandom_range(0, 3));
      ru  = 1'($urandom_range(0, 1));
      rrd = 1'($urandom_range(0, 1));
      rwr = 1'($urandom_range(0, 1));
      e   = model_load(ra, rt, ru);
`ifdef DMEM_READ_GATE_EN
      if (!rrd) e = 32'h0;
`endif
      cycle(ra, rwd, rrd, rwr, rt, ru, 1'b1, e, "random");
    end
    for (int w = 0; w < NUM_LOCS; w++)
      load(32'(w*4), LS_WORD, 1'b0, model_load(32'(w*4), LS_WORD, 1'b0), "random_sweep");

    // Reset asserted between edges while a store is pending.
    address = 32'h04; write_data = 32'h5555_5555; mem_read = 1'b1; mem_write = 1'b1;
    load_store_type = LS_WORD; load_unsigned = 1'b0;
    exp_q.push_back(32'h0);
    name_q.push_back("load_in_reset");
    chk_req = 1'b1;
    #2;
    rstn = 1'b0;
    model_clear();
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_req = 1'b0;
    rstn = 1'b1;
    load(32'h04, LS_WORD, 1'b0, 32'h0, "store_in_reset_dropped");
    load(32'h0C, LS_WORD, 1'b0, 32'h0, "reset_cleared_0c");
    load(32'h1C, LS_WORD, 1'b0, 32'h0, "reset_cleared_1c");
    load(32'h00, LS_WORD, 1'b0, 32'h0, "reset_cleared_00");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
